// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF (IEC 60958 consumer) transmitter.
// Optional channel-status feature: define SPDIF_TX_CHSTAT_EN to send CHSTAT on the C bit.
package spdif_pkg;

   // Preamble patterns, first cell in the MSB
   localparam logic [7:0] PRE_B = 8'b1110_1000;   // left subframe, frame 0
   localparam logic [7:0] PRE_M = 8'b1110_0010;   // left subframe, other frames
   localparam logic [7:0] PRE_W = 8'b1110_0100;   // right subframe

   // Slot positions of the trailing status bits
   localparam int SLOT_V = 28;
   localparam int SLOT_U = 29;
   localparam int SLOT_C = 30;
   localparam int SLOT_P = 31;

   localparam int FRAMES_PER_BLOCK   = 192;
   localparam int CELLS_PER_SUBFRAME = 64;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/spdif_encoder_if.sv
// Sample-side handshake and serial-output bundle of the S/PDIF transmitter.
// The master side supplies samples and enable; the slave side is the encoder.
interface spdif_encoder_if;

   logic        enable;
   logic [23:0] sample_l;
   logic [23:0] sample_r;
   logic        sample_valid;
   logic        sample_ready;
   logic        tx_out;
   logic        block_start;
   logic        underrun;

   modport master (
      output enable, sample_l, sample_r, sample_valid,
      input  sample_ready, tx_out, block_start, underrun
   );

   modport slave (
      input  enable, sample_l, sample_r, sample_valid,
      output sample_ready, tx_out, block_start, underrun
   );

endinterface

// File: rtl/spdif_bmc_cell.sv
// One-cell biphase-mark step: computes the line level of the next half-bit cell.
// Preamble cells are the pattern bit relative to the level that ended the previous
// subframe; data cells toggle at slot start and again mid-slot for a 1.
module spdif_bmc_cell
   import spdif_pkg::*;
(
   input  logic bit_i,     // slot bit (only used on the second cell of a slot)
   input  logic phase_i,   // 0 = first cell of slot, 1 = second cell
   input  logic pre_i,     // cell belongs to the preamble
   input  logic pat_i,     // preamble pattern bit for this cell
   input  logic prev_i,    // reference level (previous cell, or subframe-end level for preambles)
   output logic lvl_o
);

   // Select the BMC rule for this cell
   always_comb begin
      lvl_o = prev_i;
      if (pre_i)
         lvl_o = pat_i ^ prev_i;
      else if (!phase_i)
         lvl_o = ~prev_i;
      else
         lvl_o = prev_i ^ bit_i;
   end

endmodule

// File: rtl/spdif_encoder.sv
// S/PDIF consumer transmitter: serialises 24-bit stereo pairs into a BMC stream with
// B/M/W preambles, V/U/C/P bits and 192-frame blocks.
// Optional feature macro: SPDIF_TX_CHSTAT_EN (C bit taken from CHSTAT in frames 0..31).
module spdif_encoder
   import spdif_pkg::*;
#(
   parameter int          CELL_DIV = 8,
   parameter logic [31:0] CHSTAT   = 32'h0000_0004
) (
   input  logic           clk_in,
   input  logic           resetb,
   spdif_encoder_if.slave bus
);

   localparam int DW = (CELL_DIV > 1) ? $clog2(CELL_DIV) : 1;

   state_t        state_q;
   logic [DW-1:0] div_cnt_q;
   logic [5:0]    cell_q;
   logic          sub_q;
   logic [7:0]    frame_q;
   logic          tx_q;        // line level register
   logic          pre_lvl_q;   // level that ended the previous subframe
   logic          par_q;
   logic [23:0]   smp_l_q;
   logic [23:0]   smp_r_q;
   logic          v_q;
   logic          ready_q;
   logic          bstart_q;

   logic          tick, frame_end, start, advance;
   logic [5:0]    cell_d;
   logic          sub_d;
   logic [7:0]    frame_d;
   logic [4:0]    slot_d;
   logic [4:0]    data_idx;
   logic [23:0]   data_sel;
   logic [7:0]    pre_pat;
   logic          is_pre, pat_bit, c_bit, slot_bit, lvl_prev, par_d, lvl_d;

   // Position and inputs of the cell that the next level update will emit
   always_comb begin
      tick      = (state_q == ST_RUN) && (div_cnt_q == DW'(CELL_DIV - 1));
      frame_end = tick && (cell_q == 6'(CELLS_PER_SUBFRAME - 1)) && sub_q;
      start     = (state_q == ST_IDLE) && bus.enable;
      advance   = start || (tick && !(frame_end && !bus.enable));

      cell_d  = cell_q + 6'd1;
      sub_d   = sub_q;
      frame_d = frame_q;
      if (start) begin
         cell_d  = 6'd0;
         sub_d   = 1'b0;
         frame_d = 8'd0;
      end else if (cell_q == 6'(CELLS_PER_SUBFRAME - 1)) begin
         sub_d = ~sub_q;
         if (sub_q)
            frame_d = (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_q + 8'd1;
      end

      slot_d   = cell_d[5:1];
      is_pre   = (cell_d[5:3] == 3'd0);
      data_idx = slot_d - 5'd4;
      data_sel = sub_d ? smp_r_q : smp_l_q;
      pre_pat  = sub_d ? PRE_W : ((frame_d == 8'd0) ? PRE_B : PRE_M);
      pat_bit  = pre_pat[3'd7 - cell_d[2:0]];

`ifdef SPDIF_TX_CHSTAT_EN
      c_bit = (frame_d < 8'd32) ? CHSTAT[frame_d[4:0]] : 1'b0;
`else
      // Channel status disabled: C is always 0 (CHSTAT referenced only to keep it bound)
      c_bit = CHSTAT[0] & 1'b0;
`endif

      if (slot_d == 5'(SLOT_P))
         slot_bit = par_q;
      else if (slot_d == 5'(SLOT_C))
         slot_bit = c_bit;
      else if (slot_d == 5'(SLOT_U))
         slot_bit = 1'b0;
      else if (slot_d == 5'(SLOT_V))
         slot_bit = v_q;
      else
         slot_bit = data_sel[data_idx];

      // Preambles reference the level at the end of the previous subframe
      lvl_prev = tx_q;
      if (is_pre && (cell_d != 6'd0))
         lvl_prev = pre_lvl_q;

      // Serial even parity over slots 4..30, folded in on each slot's second cell
      par_d = par_q;
      if (cell_d == 6'd0)
         par_d = 1'b0;
      else if (cell_d[0] && !is_pre && (slot_d != 5'(SLOT_P)))
         par_d = par_q ^ slot_bit;
   end

   spdif_bmc_cell u_bmc (
      .bit_i   (slot_bit),
      .phase_i (cell_d[0]),
      .pre_i   (is_pre),
      .pat_i   (pat_bit),
      .prev_i  (lvl_prev),
      .lvl_o   (lvl_d)
   );

   // Control FSM, counters, sample latch and registered line output
   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= '0;
         cell_q    <= 6'd0;
         sub_q     <= 1'b0;
         frame_q   <= 8'd0;
         tx_q      <= 1'b0;
         pre_lvl_q <= 1'b0;
         par_q     <= 1'b0;
         smp_l_q   <= 24'd0;
         smp_r_q   <= 24'd0;
         v_q       <= 1'b0;
         ready_q   <= 1'b0;
         bstart_q  <= 1'b0;
      end else begin
         ready_q  <= 1'b0;
         bstart_q <= 1'b0;

         // Accept (or substitute silence for) the pair in the first cycle of the frame
         if (ready_q) begin
            smp_l_q <= bus.sample_valid ? bus.sample_l : 24'd0;
            smp_r_q <= bus.sample_valid ? bus.sample_r : 24'd0;
            v_q     <= ~bus.sample_valid;
         end

         if (state_q == ST_RUN)
            div_cnt_q <= tick ? '0 : div_cnt_q + DW'(1);

         if (frame_end && !bus.enable) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b0;
            frame_q <= 8'd0;
            cell_q  <= 6'd0;
            sub_q   <= 1'b0;
         end else if (advance) begin
            state_q <= ST_RUN;
            cell_q  <= cell_d;
            sub_q   <= sub_d;
            frame_q <= frame_d;
            tx_q    <= lvl_d;
            par_q   <= par_d;
            if (cell_d == 6'd0)
               pre_lvl_q <= tx_q;
            if ((cell_d == 6'd0) && !sub_d) begin
               ready_q  <= 1'b1;
               bstart_q <= (frame_d == 8'd0);
            end
         end
      end
   end

   assign bus.tx_out       = tx_q;
   assign bus.sample_ready = ready_q;
   assign bus.block_start  = bstart_q;
   // Must coincide with the accept cycle, so it is decoded from the live valid input
   assign bus.underrun     = ready_q & ~bus.sample_valid;

endmodule

// File: tb/tb_spdif_encoder.sv
// Directed bench for spdif_encoder: captures whole frames of BMC cells, decodes them
// independently (preambles, slot toggles, bits, parity, end level) and compares against
// hand-computed values. Honours SPDIF_TX_CHSTAT_EN for the expected C bit.
module tb_spdif_encoder;

   localparam int CD        = 2;
   localparam int FRAME_CYC = 128 * CD;
   localparam logic [7:0] B_PRE = 8'b1110_1000;
   localparam logic [7:0] M_PRE = 8'b1110_0010;
   localparam logic [7:0] W_PRE = 8'b1110_0100;
`ifdef SPDIF_TX_CHSTAT_EN
   localparam logic C2 = 1'b1;
`else
   localparam logic C2 = 1'b0;
`endif

   logic clk    = 1'b0;
   logic resetb = 1'b0;

   spdif_encoder_if bus();

   spdif_encoder #(.CELL_DIV(CD), .CHSTAT(32'h0000_0004)) dut (
      .clk_in (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   logic cells [0:127];
   int   cap_sr, cap_ur, cap_bs, t_sr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_pre(input int sb);
      logic [7:0] p;
      logic       ref_lvl;
      ref_lvl = (sb == 0) ? 1'b0 : cells[63];
      for (int i = 0; i < 8; i++) p[7-i] = cells[sb*64 + i] ^ ref_lvl;
      return p;
   endfunction

   // Wait for the frame-start strobe, then record one frame of cells and strobe counts
   task automatic capture(input int drop_at);
      int w;
      w = 0;
      cap_sr = 0; cap_ur = 0; cap_bs = 0;
      do begin
         @(negedge clk);
         w++;
      end while (bus.sample_ready !== 1'b1 && w < 1000);
      if (bus.sample_ready !== 1'b1) begin
         chk("sr_timeout", {31'd0, bus.sample_ready}, 32'd1);
         return;
      end
      t_sr = cyc_cnt;
      for (int c = 0; c < FRAME_CYC; c++) begin
         if (c > 0) @(negedge clk);
         if (c == drop_at) bus.enable = 1'b0;
         if (c % CD == 0) cells[c/CD] = bus.tx_out;
         cap_sr += int'(bus.sample_ready);
         cap_ur += int'(bus.underrun);
         cap_bs += int'(bus.block_start);
      end
   endtask

   task automatic check_sub(input string tag, input int sb, input logic [7:0] ep,
                            input logic [23:0] ed, input logic ev, input logic ec, input logic epar);
      logic [27:0] bits;
      int          b, bad_tog;
      b = sb * 64;
      bad_tog = 0;
      for (int s = 4; s < 32; s++) begin
         if (cells[b + 2*s] === cells[b + 2*s - 1]) bad_tog++;
         bits[s-4] = cells[b + 2*s] ^ cells[b + 2*s + 1];
      end
      chk({tag, ".pre"},  get_pre(sb), ep);
      chk({tag, ".data"}, bits[23:0], ed);
      chk({tag, ".V"},    bits[24], ev);
      chk({tag, ".U"},    bits[25], 1'b0);
      chk({tag, ".C"},    bits[26], ec);
      chk({tag, ".P"},    bits[27], epar);
      chk({tag, ".tog"},  bad_tog, 0);
      chk({tag, ".end"},  cells[b + 63], 1'b0);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] lpre, input logic [23:0] ld,
                              input logic [23:0] rd, input logic v, input logic c,
                              input logic lpar, input logic rpar, input int exp_ur, input int exp_bs);
      chk({tag, ".sr"}, cap_sr, 1);
      chk({tag, ".ur"}, cap_ur, exp_ur);
      chk({tag, ".bs"}, cap_bs, exp_bs);
      check_sub({tag, ".L"}, 0, lpre,  ld, v, c, lpar);
      check_sub({tag, ".R"}, 1, W_PRE, rd, v, c, rpar);
   endtask

   initial begin
      int w, t0, bad_pre, bad_end, bad_bs;
      bus.enable = 1'b0; bus.sample_valid = 1'b0;
      bus.sample_l = 24'd0; bus.sample_r = 24'd0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.tx", bus.tx_out, 1'b0);
      chk("rst.sr", bus.sample_ready, 1'b0);
      chk("rst.bs", bus.block_start, 1'b0);
      chk("rst.ur", bus.underrun, 1'b0);
      resetb = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle.tx", bus.tx_out, 1'b0);
      chk("idle.sr", bus.sample_ready, 1'b0);

      // Frame 0: L=1, R=0
      bus.sample_l = 24'h000001; bus.sample_r = 24'h000000; bus.sample_valid = 1'b1;
      bus.enable = 1'b1;
      capture(-1);
      $display("frame0: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("f0", B_PRE, 24'h000001, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
      chk("f0.rawB", get_pre(0), 8'b1110_1000);

      // Frame 1: single MSB left, 23 ones right
      bus.sample_l = 24'h800000; bus.sample_r = 24'h7FFFFF;
      capture(-1);
      $display("frame1: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("f1", M_PRE, 24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);

      // Frame 2: channel-status bit 2
      bus.sample_l = 24'h000003; bus.sample_r = 24'h000000;
      capture(-1);
      $display("frame2: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("f2", M_PRE, 24'h000003, 24'h000000, 1'b0, C2, C2, C2, 0, 0);

      // Frame 3: underrun -> zeros, V=1
      bus.sample_l = 24'hFFFFFF; bus.sample_r = 24'hFFFFFF; bus.sample_valid = 1'b0;
      capture(-1);
      $display("frame3: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("f3", M_PRE, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0);

      // Frame 4: valid resumes
      bus.sample_l = 24'h5A5A5A; bus.sample_r = 24'h000010; bus.sample_valid = 1'b1;
      capture(-1);
      $display("frame4: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("f4", M_PRE, 24'h5A5A5A, 24'h000010, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

      // Frame 5: enable dropped mid-left-subframe; the frame still completes
      bus.sample_l = 24'h123456; bus.sample_r = 24'h000000;
      capture(40);
      $display("frame5: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("f5", M_PRE, 24'h123456, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      cap_sr = 0; w = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cap_sr += int'(bus.sample_ready);
         w += int'(bus.tx_out);
      end
      $display("idle: sr=%0d tx_ones=%0d", cap_sr, w);
      chk("drop.sr", cap_sr, 0);
      chk("drop.tx", w, 0);

      // Re-enable: block restarts with B
      bus.sample_l = 24'h000001; bus.sample_r = 24'h000000;
      bus.enable = 1'b1;
      capture(-1);
      $display("reen: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("reen", B_PRE, 24'h000001, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);

      // Asynchronous reset while the line is high
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (bus.tx_out !== 1'b1 && w < 64);
      chk("arst.pre_tx", bus.tx_out, 1'b1);
      resetb = 1'b0;
      #1;
      $display("async reset: tx=%0b sr=%0b bs=%0b ur=%0b", bus.tx_out, bus.sample_ready, bus.block_start, bus.underrun);
      chk("arst.tx", bus.tx_out, 1'b0);
      chk("arst.sr", bus.sample_ready, 1'b0);
      chk("arst.bs", bus.block_start, 1'b0);
      chk("arst.ur", bus.underrun, 1'b0);
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      capture(-1);
      $display("restart: sr=%0d ur=%0d bs=%0d", cap_sr, cap_ur, cap_bs);
      check_frame("rs", B_PRE, 24'h000001, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1);
      t0 = t_sr;

      // Rest of the block: (M,W) x191, then B again after exactly one block period
      bad_pre = 0; bad_end = 0; bad_bs = 0;
      for (int f = 1; f < 192; f++) begin
         capture(-1);
         if (get_pre(0) !== M_PRE || get_pre(1) !== W_PRE) bad_pre++;
         if (cells[63] !== 1'b0 || cells[127] !== 1'b0) bad_end++;
         bad_bs += cap_bs;
      end
      $display("block: bad_pre=%0d bad_end=%0d stray_bs=%0d", bad_pre, bad_end, bad_bs);
      chk("blk.pre", bad_pre, 0);
      chk("blk.end", bad_end, 0);
      chk("blk.bs",  bad_bs, 0);
      capture(-1);
      $display("wrap: bs=%0d period=%0d", cap_bs, t_sr - t0);
      chk("wrap.bs",     cap_bs, 1);
      chk("wrap.pre",    get_pre(0), B_PRE);
      chk("wrap.period", t_sr - t0, 192 * 128 * CD);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed of %0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spdif_encoder.md
Name: spdif_encoder

Overview:
- S/PDIF (IEC 60958 consumer) transmitter; the transmit end of the link the amp frontend's decoder receives.
- Takes parallel 24-bit stereo sample pairs and emits a biphase-mark-coded serial stream on tx_out.
- Generates B/M/W preambles, V/U/C/P bits and the 192-frame block structure.
- Used for loopback test and daisy-chaining audio to the next amplifier.

Parameters:
- CELL_DIV, 8, clk_in cycles per BMC half-bit cell; must be >= 2. At 48.36 MHz this gives 47.2 kHz frames.
- CHSTAT, 32'h0000_0004, channel-status bits 0..31, sent on C in frames 0..31 (consumer, audio, copy permitted).

Ports:
- clk_in  in  1  system clock, single domain.
- resetb  in  1  asynchronous active-low reset.
- enable  in  1  transmit enable, sampled only at frame boundaries.
- sample_l  in  24  left sample, two's complement.
- sample_r  in  24  right sample, two's complement.
- sample_valid  in  1  sample pair available.
- sample_ready  out  1  one-cycle accept strobe.
- tx_out  out  1  BMC serial output.
- block_start  out  1  one-cycle pulse at the start of frame 0.
- underrun  out  1  one-cycle pulse when no sample is available at a frame start.

Behaviour:
- Reset (asynchronous, resetb=0): tx_out=0, sample_ready=0, block_start=0, underrun=0, line level register=0, all counters=0, state IDLE.
- Counters:
  - div_cnt 0..CELL_DIV-1; a cell tick occurs when div_cnt=CELL_DIV-1.
  - cell_cnt 0..63 per subframe.
  - sub (0=left, 1=right).
  - frame_cnt 0..191, wraps 191->0.
- State IDLE:
  - tx_out held at 0; counters held; frame_cnt forced to 0.
  - On enable=1, go to RUN. The first cell starts on the next clk_in cycle and is a frame start.
- State RUN, frame start (cell 0 of the left subframe), first clk_in cycle of the cell:
  - sample_ready=1 for exactly one cycle.
  - If sample_valid=1: latch sample_l/sample_r; V=0 for both subframes.
  - If sample_valid=0: latch zeros, set V=1 for both subframes, pulse underrun in the same cycle.
  - If frame_cnt=0: pulse block_start in the same cycle.
  - The latched pair is transmitted in this same frame; latency from accept to first data cell is 8 cells.
- Enable drop: enable is sampled at the last cell tick of the right subframe. If enable=0, go to IDLE after that cell and drive tx_out=0. No partial frames are ever sent.
- Subframe layout, 32 slots of 2 cells each:
  - Slots 0-3: preamble, 8 cells. Pattern is B=11101000 (left, frame 0), M=11100010 (other left), W=11100100 (right).
  - Each preamble cell level = pattern bit XOR line level at end of the previous subframe.
  - Slots 4-27: sample bits 0..23, LSB first.
  - Slot 28: V. Slot 29: U=0. Slot 30: C = CHSTAT[frame_cnt] if frame_cnt<32, else 0. The same C bit is used in both subframes.
  - Slot 31: P = even parity over slots 4-30.
- BMC for slots 4-31:
  - The level toggles at the start of every slot.
  - The level toggles again at mid-slot when the bit is 1.
  - The parity rule guarantees the line level at the end of every subframe is 0. Assert this in simulation.
- tx_out is registered and changes only on cell ticks.
- Parity is accumulated serially; no 28-bit combinational tree.

Optional Feature:
- Macro SPDIF_TX_CHSTAT_EN.
  - Defined: C bit is sourced from CHSTAT as above.
  - Undefined: C=0 in all frames, and the CHSTAT parameter is ignored.
- Parity always covers whatever C value is sent.

Decomposition:
- Package spdif_pkg:
  - preamble constants PRE_B, PRE_M, PRE_W (8 bits each);
  - slot indices SLOT_V=28, SLOT_U=29, SLOT_C=30, SLOT_P=31;
  - FRAMES_PER_BLOCK=192; CELLS_PER_SUBFRAME=64.
- Sub-module spdif_bmc_cell: given slot bit, cell phase, preamble flag/pattern bit and previous level, produces the next cell level. The top module holds the counters, handshake and parity.

Test Plan:
- Reset, then enable=1, sample_valid=1, L=24'h000001, R=24'h000000 -> first 8 tx cells 1,1,1,0,1,0,0,0 (B). Left P=1, right P=0. Line level 0 at the end of each subframe.
- Continuous valid stream with CELL_DIV=8 -> block_start pulses every 196608 clk_in cycles. Preamble sequence is B,W then (M,W)x191.
- sample_valid=0 at one frame start -> underrun pulses once. Both subframes carry zero data with V=1 and correct parity. The next frame with valid resumes V=0.
- Drop enable mid-left-subframe -> the frame completes, then tx_out=0 with no further sample_ready. Re-enable -> the next frame preamble is B.
- With SPDIF_TX_CHSTAT_EN, CHSTAT=32'h0000_0004 -> C=1 only in frame 2, both subframes. Without the macro, C=0 in all frames.
- Assert resetb low mid-subframe -> all outputs 0 immediately. After release, behaviour is identical to a cold start.
